// File: rtl/mole_game_ctrl_pkg.sv
// Shared definitions for the whack-a-mole game sequencer: state encoding,
// hole count, LFSR feedback mask and a one-hot helper.
package mole_game_ctrl_pkg;

  // Encoding is shared with the time counter, display and scoring blocks.
  typedef enum logic [1:0] {
    ST_STANDBY = 2'd0,
    ST_POP     = 2'd1,
    ST_GAP     = 2'd2,
    ST_OVER    = 2'd3
  } game_state_e;

  localparam int HOLE_NUM = 10;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1 (maximal length).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One-hot LED pattern for a hole index.
  function automatic logic [HOLE_NUM-1:0] hole_onehot(input logic [3:0] idx);
    hole_onehot = HOLE_NUM'(1) << idx;
  endfunction

endpackage

// File: rtl/mole_game_ctrl_hole_lfsr.sv
// Pseudo-random hole picker: free-running 8-bit Galois LFSR, mod-10 fold of
// the low nibble, and a bump to the next hole when the pick repeats.
module mole_game_ctrl_hole_lfsr
  import mole_game_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] prev_idx_i,
  output logic [3:0] idx_o,
  output logic [7:0] lfsr_o
);

  localparam logic [3:0] HOLES     = 4'(HOLE_NUM);
  localparam logic [3:0] LAST_HOLE = 4'(HOLE_NUM - 1);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [3:0] raw;
  logic [3:0] folded;

  // Galois step: shift right, fold the tap mask in when a one drops out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[7:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  // LFSR advances every cycle so the sequence depends on player timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Fold 0..15 onto 0..9, then avoid repeating the previous hole.
  always_comb begin
    raw    = lfsr_q[3:0];
    folded = (raw >= HOLES) ? (raw - HOLES) : raw;
    idx_o  = folded;
    if (folded == prev_idx_i) begin
      idx_o = (folded == LAST_HOLE) ? 4'd0 : (folded + 4'd1);
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Top-level whack-a-mole sequencer: game FSM, pop/gap phase counter, game
// timer, hit detection on button rising edges and saturating score.
module mole_game_ctrl
  import mole_game_ctrl_pkg::*;
#(
  parameter int         GAME_TICKS = 600,
  parameter int         POP_TICKS  = 8,
  parameter int         GAP_TICKS  = 4,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start,
  input  logic [HOLE_NUM-1:0] hamster_op,
  output logic [1:0]          state,
  output logic [HOLE_NUM-1:0] hole_up,
  output logic [7:0]          score,
  output logic [9:0]          time_left,
  output logic                hit_pulse,
  output logic                miss_pulse
);

  localparam int PHASE_MAX = (POP_TICKS > GAP_TICKS) ? POP_TICKS : GAP_TICKS;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [PHASE_W-1:0] PHASE_POP = PHASE_W'(POP_TICKS);
  localparam logic [PHASE_W-1:0] PHASE_GAP = PHASE_W'(GAP_TICKS);
  localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
  localparam logic [9:0]         TIME_FULL = 10'(GAME_TICKS);

  game_state_e         state_q,     state_d;
  logic [HOLE_NUM-1:0] hole_up_q,   hole_up_d;
  logic [7:0]          score_q,     score_d;
  logic [9:0]          time_left_q, time_left_d;
  logic                hit_q,       hit_d;
  logic                miss_q,      miss_d;
  logic [PHASE_W-1:0]  phase_q,     phase_d;
  logic [HOLE_NUM-1:0] op_q,        op_d;
  logic [3:0]          prev_idx_q,  prev_idx_d;

  logic [3:0] idx;
  logic [7:0] lfsr_unused;
  logic       hit;
  logic       in_play;

  mole_game_ctrl_hole_lfsr #(
    .SEED(LFSR_SEED)
  ) u_hole_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .prev_idx_i(prev_idx_q),
    .idx_o     (idx),
    .lfsr_o    (lfsr_unused)
  );

  // A hit is a fresh press on the hole that is currently raised.
  always_comb begin
    hit     = (state_q == ST_POP) && (|(hamster_op & ~op_q & hole_up_q));
    in_play = (state_q == ST_GAP) || (state_q == ST_POP);
  end

  // Next-state logic: phase transitions first, game-time expiry overrides.
  always_comb begin
    state_d     = state_q;
    hole_up_d   = hole_up_q;
    score_d     = score_q;
    time_left_d = time_left_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    phase_d     = phase_q;
    op_d        = hamster_op;
    prev_idx_d  = prev_idx_q;

    unique case (state_q)
      ST_STANDBY, ST_OVER: begin
        hole_up_d = '0;
        if (start) begin
          score_d     = 8'd0;
          time_left_d = TIME_FULL;
          phase_d     = PHASE_GAP;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        hole_up_d = '0;
        if (tick) begin
          phase_d = phase_q - PHASE_ONE;
          if (phase_q == PHASE_ONE) begin
            hole_up_d  = hole_onehot(idx);
            prev_idx_d = idx;
            phase_d    = PHASE_POP;
            state_d    = ST_POP;
          end
        end
      end
      ST_POP: begin
        if (hit) begin
          score_d   = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
          hit_d     = 1'b1;
          hole_up_d = '0;
          phase_d   = PHASE_GAP;
          state_d   = ST_GAP;
        end else if (tick && (phase_q == PHASE_ONE)) begin
          miss_d    = 1'b1;
          hole_up_d = '0;
          phase_d   = PHASE_GAP;
          state_d   = ST_GAP;
        end else if (tick) begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
      default: begin
        state_d = ST_STANDBY;
      end
    endcase

    // Running out of time ends the game regardless of the pop/gap outcome;
    // a simultaneous hit still counts but an expiring pop is not a miss.
    if (in_play && tick) begin
      if (time_left_q == 10'd1) begin
        time_left_d = 10'd0;
        hole_up_d   = '0;
        miss_d      = 1'b0;
        state_d     = ST_OVER;
      end else begin
        time_left_d = time_left_q - 10'd1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STANDBY;
      hole_up_q   <= '0;
      score_q     <= 8'd0;
      time_left_q <= TIME_FULL;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      phase_q     <= '0;
      op_q        <= '0;
      prev_idx_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      hole_up_q   <= hole_up_d;
      score_q     <= score_d;
      time_left_q <= time_left_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      phase_q     <= phase_d;
      op_q        <= op_d;
      prev_idx_q  <= prev_idx_d;
    end
  end

  assign state      = state_q;
  assign hole_up    = hole_up_q;
  assign score      = score_q;
  assign time_left  = time_left_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule
